// File: rtl/car_emu_pkg.sv
// Shared types and constants for the car sensor emulator.
//   state_t     : emulator FSM states
//   dir_t       : direction of the car latched at request acceptance
//   SENS_*      : {outer, inner} encodings for each phase
//   sensor_code : {outer, inner} driven for a given state/direction
package car_emu_pkg;

   localparam int unsigned TMR_W = 8;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      PH_A = 3'd1,
      PH_B = 3'd2,
      PH_C = 3'd3,
      GAP  = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      ENTER = 2'd0,
      EXIT  = 2'd1,
      PED   = 2'd2
   } dir_t;

   localparam logic [1:0] SENS_CLEAR = 2'b00;
   localparam logic [1:0] SENS_OUTER = 2'b10;
   localparam logic [1:0] SENS_INNER = 2'b01;
   localparam logic [1:0] SENS_BOTH  = 2'b11;

   // {outer, inner} for a phase; adjacent phases differ in exactly one bit
   function automatic logic [1:0] sensor_code(input state_t s, input dir_t d);
      logic [1:0] code;
      code = SENS_CLEAR;
      case (s)
         PH_A:    code = (d == EXIT) ? SENS_INNER : SENS_OUTER;
         PH_B:    code = SENS_BOTH;
         PH_C:    code = (d == EXIT) ? SENS_OUTER : SENS_INNER;
         default: code = SENS_CLEAR;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/car_sensor_emulator_phase_timer.sv
// Loadable down-counter timing one emulator phase.
//   clk, rst_n : clock, async active-low reset
//   load       : reload with load_val (phase lasts load_val cycles)
//   load_val   : phase length in cycles, 1..255
//   expire     : high during the last cycle of the phase (registered)
module phase_timer
   import car_emu_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [TMR_W-1:0] load_val,
   output logic             expire
);

   logic [TMR_W-1:0] cnt_q;
   logic [TMR_W-1:0] cnt_d;

   // Count remaining cycles after the current one; hold at zero when done
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val - TMR_W'(1);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - TMR_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         expire <= 1'b1;
      end else begin
         cnt_q  <= cnt_d;
         expire <= (cnt_d == '0);
      end
   end

endmodule

// File: rtl/car_sensor_emulator.sv
// Car sensor emulator: turns single-cycle enter/exit requests into the
// outer/inner photosensor blocking sequence of one car, and tracks the
// occupancy a correct detector should report.
// Optional feature macro: CAR_EMU_PEDESTRIAN_EN (adds ped_req, a
// PH_A-only sequence that must not change the count).
//   clk        : system clock, rising edge
//   reset      : async active-low reset
//   enter_req  : request one entering car (sampled when ready)
//   exit_req   : request one exiting car (sampled when ready)
//   ped_req    : request a pedestrian event (feature build only)
//   ready      : high in IDLE only
//   outer      : emulated outer sensor, 1 = blocked
//   inner      : emulated inner sensor, 1 = blocked
//   done       : one-cycle pulse in the first GAP cycle
//   exp_count  : expected occupancy, saturating
module car_sensor_emulator
   import car_emu_pkg::*;
#(
   parameter int unsigned PHASE_CYCLES = 4,
   parameter int unsigned GAP_CYCLES   = 2,
   parameter int unsigned CNT_W        = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enter_req,
   input  logic             exit_req,
`ifdef CAR_EMU_PEDESTRIAN_EN
   input  logic             ped_req,
`endif
   output logic             ready,
   output logic             outer,
   output logic             inner,
   output logic             done,
   output logic [CNT_W-1:0] exp_count
);

   localparam logic [TMR_W-1:0] PHASE_LEN = TMR_W'(PHASE_CYCLES);
   localparam logic [TMR_W-1:0] GAP_LEN   = TMR_W'(GAP_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   state_t           state_q, state_d;
   dir_t             dir_q, dir_d;
   logic             tmr_load;
   logic [TMR_W-1:0] tmr_val;
   logic             tmr_expire;
   logic             done_d;
   logic [CNT_W-1:0] count_d;
   logic [1:0]       sens_d;

   phase_timer u_timer (
      .clk      (clk),
      .rst_n    (reset),
      .load     (tmr_load),
      .load_val (tmr_val),
      .expire   (tmr_expire)
   );

   // Next state, timer reload and next registered outputs
   always_comb begin
      state_d  = state_q;
      dir_d    = dir_q;
      tmr_load = 1'b0;
      tmr_val  = PHASE_LEN;
      count_d  = exp_count;
      done_d   = 1'b0;
      sens_d   = SENS_CLEAR;

      case (state_q)
         IDLE: begin
            // ENTER has priority; a coincident exit is dropped
            if (enter_req) begin
               dir_d    = ENTER;
               state_d  = PH_A;
               tmr_load = 1'b1;
            end else if (exit_req) begin
               dir_d    = EXIT;
               state_d  = PH_A;
               tmr_load = 1'b1;
            end
`ifdef CAR_EMU_PEDESTRIAN_EN
            else if (ped_req) begin
               dir_d    = PED;
               state_d  = PH_A;
               tmr_load = 1'b1;
            end
`endif
         end
         PH_A: begin
            if (tmr_expire) begin
               tmr_load = 1'b1;
`ifdef CAR_EMU_PEDESTRIAN_EN
               // A pedestrian only blocks the outer sensor, then leaves
               if (dir_q == PED) begin
                  state_d = GAP;
                  tmr_val = GAP_LEN;
               end else begin
                  state_d = PH_B;
               end
`else
               state_d = PH_B;
`endif
            end
         end
         PH_B: begin
            if (tmr_expire) begin
               state_d  = PH_C;
               tmr_load = 1'b1;
            end
         end
         PH_C: begin
            if (tmr_expire) begin
               state_d  = GAP;
               tmr_load = 1'b1;
               tmr_val  = GAP_LEN;
            end
         end
         GAP: begin
            if (tmr_expire) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Completion is the entry into GAP; the count moves on that same edge
      if ((state_d == GAP) && (state_q != GAP)) begin
         done_d = 1'b1;
         case (dir_q)
            ENTER:   if (exp_count != CNT_MAX) count_d = exp_count + CNT_W'(1);
            EXIT:    if (exp_count != '0)      count_d = exp_count - CNT_W'(1);
            default: count_d = exp_count;
         endcase
      end

      sens_d = sensor_code(state_d, dir_d);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         dir_q     <= ENTER;
         ready     <= 1'b1;
         outer     <= 1'b0;
         inner     <= 1'b0;
         done      <= 1'b0;
         exp_count <= '0;
      end else begin
         state_q   <= state_d;
         dir_q     <= dir_d;
         ready     <= (state_d == IDLE);
         outer     <= sens_d[1];
         inner     <= sens_d[0];
         done      <= done_d;
         exp_count <= count_d;
      end
   end

endmodule

// File: tb/tb_car_sensor_emulator.sv
// Self-checking bench for car_sensor_emulator (PHASE=4, GAP=2, CNT_W=5).
module tb_car_sensor_emulator;

   localparam int P  = 4;
   localparam int G  = 2;
   localparam int CW = 5;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          reset;
   logic          enter_req;
   logic          exit_req;
`ifdef CAR_EMU_PEDESTRIAN_EN
   logic          ped_req;
`endif
   logic          ready;
   logic          outer;
   logic          inner;
   logic          done;
   logic [CW-1:0] exp_count;

   int n_cmp = 0;
   int n_err = 0;

   car_sensor_emulator #(
      .PHASE_CYCLES (P),
      .GAP_CYCLES   (G),
      .CNT_W        (CW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .enter_req (enter_req),
      .exit_req  (exit_req),
`ifdef CAR_EMU_PEDESTRIAN_EN
      .ped_req   (ped_req),
`endif
      .ready     (ready),
      .outer     (outer),
      .inner     (inner),
      .done      (done),
      .exp_count (exp_count)
   );

   always #5 clk = ~clk;

   // Model: m_t = cycles elapsed in the current car event (0 = idle).
   // m_dir: 0 enter, 1 exit, 2 pedestrian.
   int m_t;
   int m_dir;
   int m_count;

   function automatic int done_at(input int d);
      return (d == 2) ? P + 1 : 3 * P + 1;
   endfunction

   function automatic int busy_len(input int d);
      return (d == 2) ? P + G : 3 * P + G;
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_t     <= 0;
         m_dir   <= 0;
         m_count <= 0;
      end else if (m_t == 0) begin
         if (enter_req) begin
            m_dir <= 0; m_t <= 1;
         end else if (exit_req) begin
            m_dir <= 1; m_t <= 1;
         end
`ifdef CAR_EMU_PEDESTRIAN_EN
         else if (ped_req) begin
            m_dir <= 2; m_t <= 1;
         end
`endif
      end else if (m_t == busy_len(m_dir)) begin
         m_t <= 0;
      end else begin
         m_t <= m_t + 1;
         if (m_t + 1 == done_at(m_dir)) begin
            if (m_dir == 0)      m_count <= (m_count < CMAX) ? m_count + 1 : CMAX;
            else if (m_dir == 1) m_count <= (m_count > 0) ? m_count - 1 : 0;
         end
      end
   end

   // Expected {ready, outer, inner, done, exp_count} from the model
   function automatic logic [CW+3:0] model_out();
      logic [1:0] s;
      int ph;
      s = 2'b00;
      if (m_t != 0 && m_t < done_at(m_dir)) begin
         ph = (m_t - 1) / P;
         if (m_dir == 2)      s = 2'b10;
         else if (ph == 1)    s = 2'b11;
         else if (m_dir == 0) s = (ph == 0) ? 2'b10 : 2'b01;
         else                 s = (ph == 0) ? 2'b01 : 2'b10;
      end
      return {(m_t == 0), s, (m_t == done_at(m_dir)), CW'(m_count)};
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Advance to the next falling edge and compare the DUT with the model
   task automatic step();
      logic [CW+3:0] act, exp;
      @(negedge clk);
      act = {ready, outer, inner, done, exp_count};
      exp = model_out();
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL model r/o/i/d/cnt: got %b expected %b at %0t", act, exp, $time);
      end
   endtask

   task automatic adv(input int n);
      repeat (n) step();
   endtask

   // Drive a one-cycle request; returns in cycle 1 of the accepted event
   task automatic pulse(input logic e, input logic x, input logic p);
      enter_req = e;
      exit_req  = x;
`ifdef CAR_EMU_PEDESTRIAN_EN
      ped_req   = p;
`endif
      step();
      enter_req = 1'b0;
      exit_req  = 1'b0;
`ifdef CAR_EMU_PEDESTRIAN_EN
      ped_req   = 1'b0;
`endif
      if (p) begin end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (!ready && n < 60) begin
         step();
         n++;
      end
      chk("wait_idle_timeout", int'(ready), 1);
   endtask

   initial begin
      reset     = 1'b0;
      enter_req = 1'b0;
      exit_req  = 1'b0;
`ifdef CAR_EMU_PEDESTRIAN_EN
      ped_req   = 1'b0;
`endif
      repeat (3) @(negedge clk);
      chk("reset_ready", int'(ready), 1);
      chk("reset_sens",  int'({outer, inner}), 0);
      chk("reset_done",  int'(done), 0);
      chk("reset_count", int'(exp_count), 0);
      reset = 1'b1;
      adv(2);

      // Enter: 10 in cycles 1-4, 11 in 5-8, 01 in 9-12, done in 13, ready 15
      pulse(1'b1, 1'b0, 1'b0);
      chk("enter_ph_a", int'({outer, inner}), 2);
      adv(4);
      chk("enter_ph_b", int'({outer, inner}), 3);
      adv(4);
      chk("enter_ph_c", int'({outer, inner}), 1);
      adv(4);
      chk("enter_done", int'(done), 1);
      chk("enter_count", int'(exp_count), 1);
      chk("enter_gap_sens", int'({outer, inner}), 0);
      adv(1);
      chk("enter_done_once", int'(done), 0);
      chk("enter_busy_c14", int'(ready), 0);
      adv(1);
      chk("enter_ready_c15", int'(ready), 1);

      // Exit: inner-first sequence, count back to 0
      pulse(1'b0, 1'b1, 1'b0);
      chk("exit_ph_a", int'({outer, inner}), 1);
      adv(4);
      chk("exit_ph_b", int'({outer, inner}), 3);
      adv(4);
      chk("exit_ph_c", int'({outer, inner}), 2);
      adv(4);
      chk("exit_done", int'(done), 1);
      chk("exit_count", int'(exp_count), 0);
      wait_idle();

      // Exit at zero: sequence still emitted, count saturates at 0
      pulse(1'b0, 1'b1, 1'b0);
      chk("exit0_ph_a", int'({outer, inner}), 1);
      wait_idle();
      chk("exit0_count", int'(exp_count), 0);

      // Simultaneous requests: ENTER wins
      pulse(1'b1, 1'b1, 1'b0);
      chk("both_ph_a", int'({outer, inner}), 2);
      wait_idle();
      chk("both_count", int'(exp_count), 1);
      adv(3);

      // Exit pulsed in cycle 6 of an enter sequence is ignored
      pulse(1'b1, 1'b0, 1'b0);
      adv(5);
      exit_req = 1'b1;
      step();
      exit_req = 1'b0;
      wait_idle();
      chk("busy_req_count", int'(exp_count), 2);
      adv(4);
      chk("busy_req_no_seq", int'(ready), 1);

      // Asynchronous reset in PH_B (cycle 7)
      pulse(1'b1, 1'b0, 1'b0);
      adv(6);
      chk("pre_reset_ph_b", int'({outer, inner}), 3);
      #2 reset = 1'b0;
      #1;
      chk("async_rst_sens",  int'({outer, inner}), 0);
      chk("async_rst_ready", int'(ready), 1);
      chk("async_rst_count", int'(exp_count), 0);
      step();
      reset = 1'b1;
      adv(1);
      pulse(1'b1, 1'b0, 1'b0);
      chk("post_rst_ph_a", int'({outer, inner}), 2);
      wait_idle();
      chk("post_rst_count", int'(exp_count), 1);

      // Upper saturation: 31 enters from zero, then one more
      reset = 1'b0;
      step();
      reset = 1'b1;
      step();
      for (int i = 0; i < CMAX; i++) begin
         pulse(1'b1, 1'b0, 1'b0);
         wait_idle();
      end
      chk("sat_count_31", int'(exp_count), 31);
      pulse(1'b1, 1'b0, 1'b0);
      chk("sat_seq_emitted", int'({outer, inner}), 2);
      wait_idle();
      chk("sat_count_held", int'(exp_count), 31);

`ifdef CAR_EMU_PEDESTRIAN_EN
      // Pedestrian: outer only for 4 cycles, done cycle 5, ready cycle 7
      pulse(1'b0, 1'b0, 1'b1);
      chk("ped_ph_a", int'({outer, inner}), 2);
      adv(4);
      chk("ped_done", int'(done), 1);
      chk("ped_sens", int'({outer, inner}), 0);
      chk("ped_count", int'(exp_count), 31);
      adv(2);
      chk("ped_ready_c7", int'(ready), 1);
`endif

      adv(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
